// File: rtl/mic_capture_if.sv
// Bundle of the control, sample-input and memory-write signals of mic_capture_ctrl.
// The master modport is the host/memory side; the slave modport is the controller.
interface mic_capture_if;
  logic        start;
  logic        abort;
  logic [23:0] threshold;
  logic [15:0] length;
  logic        mic_enable;
  logic [23:0] sample;
  logic        sample_rdy;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_wait;
  logic        busy;
  logic        done_irq;
  logic        irq_ack;
  logic        overrun;
  logic [15:0] count;

  modport master (
    output start, abort, threshold, length, sample, sample_rdy, wr_wait, irq_ack,
    input  mic_enable, wr_en, wr_addr, wr_data, busy, done_irq, overrun, count
  );

  modport slave (
    input  start, abort, threshold, length, sample, sample_rdy, wr_wait, irq_ack,
    output mic_enable, wr_en, wr_addr, wr_data, busy, done_irq, overrun, count
  );
endinterface

// File: rtl/mic_capture_ctrl.sv
// Microphone capture controller: optional magnitude trigger, one-entry write holding register.
// Define MIC_CAPTURE_TRIGGER_EN to include the ARM state and the trigger comparator.
//
//   state   | meaning
//   IDLE    | waiting for start; outputs hold the last capture's results
//   ARM     | mic running, waiting for a sample whose magnitude reaches threshold
//   CAPTURE | storing samples until count reaches the latched length
module mic_capture_ctrl (
  input logic         clk,
  input logic         rst,
  mic_capture_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE} state_t;

  state_t      state, state_nxt;
  logic [15:0] len_q, len_nxt;
  logic        wr_en_q, wr_en_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic [23:0] data_q, data_nxt;
  logic [15:0] count_q, count_nxt;
  logic        ovr_q, ovr_nxt;
  logic        done_q, done_nxt;
  logic [15:0] count_inc;
  logic        accepted;

`ifdef MIC_CAPTURE_TRIGGER_EN
  logic [23:0] thr_q, thr_nxt;
  logic [23:0] mag;
  // Negating 0x800000 wraps back to 0x800000, which is the wanted magnitude.
  assign mag = bus.sample[23] ? (~bus.sample + 24'd1) : bus.sample;
`else
  logic unused_threshold;
  assign unused_threshold = ^bus.threshold;
`endif

  assign count_inc = count_q + 16'd1;
  assign accepted  = wr_en_q & ~bus.wr_wait;

  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    wr_en_nxt = wr_en_q;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    count_nxt = count_q;
    ovr_nxt   = ovr_q;
    done_nxt  = done_q & ~bus.irq_ack;
`ifdef MIC_CAPTURE_TRIGGER_EN
    thr_nxt   = thr_q;
`endif
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          len_nxt   = bus.length;
          count_nxt = 16'd0;
          ovr_nxt   = 1'b0;
          addr_nxt  = 16'd0;
          wr_en_nxt = 1'b0;
`ifdef MIC_CAPTURE_TRIGGER_EN
          thr_nxt   = bus.threshold;
`endif
          if (bus.length == 16'd0) begin
            done_nxt = 1'b1;
          end else begin
            done_nxt = 1'b0;
`ifdef MIC_CAPTURE_TRIGGER_EN
            state_nxt = ARM;
`else
            state_nxt = CAPTURE;
`endif
          end
        end
      end
      ARM: begin
`ifdef MIC_CAPTURE_TRIGGER_EN
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (bus.sample_rdy && (mag >= thr_q)) begin
          state_nxt = CAPTURE;
          wr_en_nxt = 1'b1;
          data_nxt  = bus.sample;
          addr_nxt  = 16'd0;
        end
`else
        state_nxt = IDLE;
`endif
      end
      CAPTURE: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          wr_en_nxt = 1'b0;
        end else if (accepted) begin
          count_nxt = count_inc;
          wr_en_nxt = 1'b0;
          if (count_inc == len_q) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (bus.sample_rdy) begin
            // Holding register frees up this cycle, so the new sample takes its place.
            wr_en_nxt = 1'b1;
            data_nxt  = bus.sample;
            addr_nxt  = count_inc;
          end
        end else if (bus.sample_rdy) begin
          if (wr_en_q) begin
            ovr_nxt = 1'b1;
          end else begin
            wr_en_nxt = 1'b1;
            data_nxt  = bus.sample;
            addr_nxt  = count_q;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      len_q   <= 16'd0;
      wr_en_q <= 1'b0;
      addr_q  <= 16'd0;
      data_q  <= 24'd0;
      count_q <= 16'd0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef MIC_CAPTURE_TRIGGER_EN
      thr_q   <= 24'd0;
`endif
    end else begin
      state   <= state_nxt;
      len_q   <= len_nxt;
      wr_en_q <= wr_en_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      count_q <= count_nxt;
      ovr_q   <= ovr_nxt;
      done_q  <= done_nxt;
`ifdef MIC_CAPTURE_TRIGGER_EN
      thr_q   <= thr_nxt;
`endif
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.mic_enable = (state != IDLE);
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = addr_q;
  assign bus.wr_data    = data_q;
  assign bus.count      = count_q;
  assign bus.overrun    = ovr_q;
  assign bus.done_irq   = done_q;
endmodule

// File: doc/mic_capture_ctrl.md
MIC_CAPTURE_CTRL -- requirements
Module: mic_capture_ctrl

Interface
REQ-001 clk  in  1  sole clock; all logic on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 start  in  1  one-cycle pulse; begins a capture when idle.
REQ-004 abort  in  1  one-cycle pulse; cancels any capture.
REQ-005 threshold  in  24  unsigned trigger magnitude, sampled on accepted start.
REQ-006 length  in  16  samples to store, sampled on accepted start.
REQ-007 mic_enable  out  1  enable to the mic receive/filter chain.
REQ-008 sample  in  24  signed two's-complement filtered audio sample.
REQ-009 sample_rdy  in  1  one-cycle strobe; sample valid.
REQ-010 wr_en  out  1  memory write request.
REQ-011 wr_addr  out  16  word address, 0-based.
REQ-012 wr_data  out  24  sample being written.
REQ-013 wr_wait  in  1  memory stall; write accepted on a cycle with wr_en=1 and wr_wait=0.
REQ-014 busy  out  1  high in ARM or CAPTURE.
REQ-015 done_irq  out  1  sticky completion interrupt.
REQ-016 irq_ack  in  1  clears done_irq.
REQ-017 overrun  out  1  sticky; a sample was dropped during the current capture.
REQ-018 count  out  16  samples accepted by memory in the current or last capture.

Function
REQ-019 The FSM SHALL have states IDLE, ARM, CAPTURE.
- IDLE -> ARM on start.
- ARM -> CAPTURE on trigger sample.
- CAPTURE -> IDLE when the count reaches the latched length.
REQ-020 start SHALL be ignored in ARM and CAPTURE; an accepted start SHALL clear count, overrun and done_irq.
REQ-021 mic_enable SHALL equal busy, registered, high from the cycle after an accepted start.
REQ-022 Trigger condition:
- magnitude = |sample| as 24-bit unsigned, with 0x800000 mapping to 0x800000.
- the trigger fires on a sample_rdy in ARM with magnitude >= latched threshold.
- threshold 0 triggers on the first sample.
REQ-023 The triggering sample SHALL be the first stored sample (address 0).
REQ-024 A stored sample SHALL be placed in a one-entry holding register.
- sample_rdy at cycle N drives wr_en=1 with wr_data/wr_addr at cycle N+1.
REQ-025 wr_en, wr_addr and wr_data SHALL stay stable until accepted.
- on acceptance, count and the next address increment by 1.
- wr_en drops the following cycle unless a new sample is loaded.
REQ-026 If sample_rdy arrives while the holding register is occupied and not accepted that cycle:
- the sample is dropped and overrun is set.
- a sample arriving in the acceptance cycle SHALL be loaded without loss.
REQ-027 On the acceptance that makes count equal length:
- the FSM enters IDLE next cycle, busy and mic_enable fall, and done_irq sets.
- further sample_rdy in that capture is ignored.
REQ-028 An accepted start with length=0:
- SHALL go directly to IDLE with done_irq set next cycle, count 0, and no writes.
REQ-029 abort in ARM or CAPTURE SHALL force IDLE next cycle.
- wr_en is dropped immediately, even mid-handshake.
- done_irq is not set; count holds the accepted total.
REQ-030 Simultaneous events:
- abort with start in IDLE: abort wins.
- irq_ack in the cycle done_irq is set: set wins.
REQ-031 wr_addr SHALL never wrap; the maximum address is length-1 (at most 0xFFFE).

Reset
REQ-032 On rst, all outputs SHALL go to 0 and the state to IDLE.
- covers mic_enable, busy, wr_en, wr_addr, wr_data, done_irq, overrun, count.
REQ-033 rst SHALL take priority over every other input, including mid-handshake with wr_wait high.

Configuration
REQ-034 With macro MIC_CAPTURE_TRIGGER_EN defined:
- the ARM state and magnitude comparator SHALL exist as specified.
REQ-035 Without MIC_CAPTURE_TRIGGER_EN:
- an accepted start goes directly to CAPTURE and the first subsequent sample is stored at address 0.
- threshold is ignored and busy excludes ARM.

Verification
REQ-036 threshold=0x000100, length=4, samples 0x000010, 0xFFFF00, 5, 6, 7 with wr_wait=0 -> stores 0xFFFF00, 5, 6, 7 at addresses 0-3; done_irq=1; count=4.
REQ-037 length=3, threshold=0, wr_wait held high 5 cycles on the first write while 2 samples arrive -> overrun=1, address-0 data stable throughout, count ends 3.
REQ-038 Sample 0x800000 with threshold 0x7FFFFF -> triggers and stores 0x800000 at address 0.
REQ-039 abort during CAPTURE after 2 accepted writes with wr_en pending -> IDLE next cycle, wr_en=0, done_irq=0, count=2.
REQ-040 start with length=0 -> done_irq=1 one cycle later, no wr_en; irq_ack plus a new start clears it; rst mid-capture -> all outputs 0.
